// File: rtl/mult_share_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_defs
// Shared definitions for the multiplier-sharing controller:
//   - state_t      : controller FSM encoding (IDLE=0, BUSY=1, RESP=2)
//   - DEF_WIDTH    : default operand width
//   - DEF_MULT_LATENCY : default multiplier calculation time in cycles
//   - clog2_min1() : index width helper, never returns less than 1
// No ports (package).
// -----------------------------------------------------------------------------
package mult_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_MULT_LATENCY = 16;

  // Width needed to index n items; a 1-bit field is kept even for n <= 2 so
  // that no zero-width vectors appear anywhere.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mult_rr_arbiter
// Combinational round-robin pick: the first set request bit at or above the
// pointer, wrapping modulo NUM_REQ.
// Ports:
//   i_req     in  NUM_REQ  request vector
//   i_ptr     in  ID_W     highest-priority index for this pick
//   o_onehot  out NUM_REQ  one-hot winner (all zero when no request)
//   o_idx     out ID_W     winner index (0 when no request)
//   o_any     out 1        at least one request is set
// -----------------------------------------------------------------------------
module mult_rr_arbiter
  import mult_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_j;
  logic            w_found;

  // NOTE: every signal written here gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_j      = '0;
    // Scan from the pointer upward; the modulo folds the search back to 0.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found       = 1'b1;
        o_idx         = w_j;
        o_onehot[w_j] = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// mult_share_ctrl
// Shares one fixed-latency multiplier between NUM_REQ requesters. A winner is
// picked round-robin, its operands are driven to the multiplier with start held
// for MULT_LATENCY cycles, then the product is returned with the requester id
// on a valid/ready response port. All outputs are registered.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req             per-requester request (held with operands until grant)
//   a_in, b_in      packed operands, requester i at [i*WIDTH +: WIDTH]
//   grant           one-hot single-cycle pulse: operands taken
//   mult_start      start to the multiplier
//   mult_a, mult_b  operands to the multiplier
//   mult_c          product from the multiplier
//   rsp_valid       response available
//   rsp_id          requester owning rsp_data
//   rsp_data        captured product
//   rsp_ready       consumer accepts the response
// -----------------------------------------------------------------------------
module mult_share_ctrl
  import mult_defs::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int WIDTH        = DEF_WIDTH,
  parameter  int MULT_LATENCY = DEF_MULT_LATENCY,
  localparam int ID_W         = clog2_min1(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     mult_start,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic [2*WIDTH-1:0]       mult_c,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_data,
  input  logic                     rsp_ready
);

  localparam int CNT_W = clog2_min1(MULT_LATENCY);

  // Registered state
  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_start;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [2*WIDTH-1:0] r_rsp_data;

  // Next-state values
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic               w_start_nxt;
  logic [WIDTH-1:0]   w_a_nxt;
  logic [WIDTH-1:0]   w_b_nxt;
  logic [ID_W-1:0]    w_id_nxt;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_rsp_valid_nxt;
  logic [ID_W-1:0]    w_rsp_id_nxt;
  logic [2*WIDTH-1:0] w_rsp_data_nxt;

  // Arbiter result
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [ID_W-1:0]    w_win_idx;
  logic               w_any;

  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = '0;          // grant is a single-cycle pulse
    w_start_nxt     = r_start;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_id_nxt        = r_id;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_data_nxt  = r_rsp_data;

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_win_onehot;
          w_start_nxt = 1'b1;
          w_a_nxt     = a_in[int'(w_win_idx)*WIDTH +: WIDTH];
          w_b_nxt     = b_in[int'(w_win_idx)*WIDTH +: WIDTH];
          w_id_nxt    = w_win_idx;
          // Next scan starts just past the winner so every requester gets a turn.
          w_ptr_nxt   = (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = BUSY;
        end
      end

      BUSY: begin
        // Counter reaches MULT_LATENCY-1 on the edge that ends the
        // MULT_LATENCY-th start cycle; that is when mult_c is valid.
        if (r_cnt == CNT_W'(MULT_LATENCY - 1)) begin
          w_rsp_data_nxt  = mult_c;
          w_rsp_id_nxt    = r_id;
          w_rsp_valid_nxt = 1'b1;
          w_start_nxt     = 1'b0;
          w_state_nxt     = RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      RESP: begin
        // No arbitration on the handshake edge; the next pick happens in IDLE.
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_start     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_start     <= w_start_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_id        <= w_id_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
    end
  end

  assign grant      = r_grant;
  assign mult_start = r_start;
  assign mult_a     = r_a;
  assign mult_b     = r_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_share_ctrl
// Directed bench for mult_share_ctrl (NUM_REQ=4, WIDTH=4, MULT_LATENCY=16).
// A transaction-level model tracks the expected outputs in absolute cycle
// numbers and a compare process checks the DUT every cycle; directed steps add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mult_share_ctrl;

  localparam int N = 4;
  localparam int W = 4;
  localparam int L = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   grant;
  logic           mult_start;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic [2*W-1:0] mult_c;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_data;
  logic           rsp_ready;

  mult_share_ctrl #(
    .NUM_REQ      (N),
    .WIDTH        (W),
    .MULT_LATENCY (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .grant      (grant),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_c     (mult_c),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Multiplier model: product is only presented on the edge that closes the
  // L-th consecutive start cycle; any other time it shows a garbage pattern.
  // ---------------------------------------------------------------------------
  int run_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) run_cnt <= 0;
    else     run_cnt <= mult_start ? run_cnt + 1 : 0;
  end
  always_comb begin
    mult_c = 8'hEE;
    if (mult_start && run_cnt == L - 1) mult_c = {4'b0, mult_a} * {4'b0, mult_b};
  end

  // ---------------------------------------------------------------------------
  // Reference model: one transaction at a time, timed by absolute cycle number.
  // ---------------------------------------------------------------------------
  int           m_cyc, m_t0, m_ptr, m_owner, m_w;
  bit           m_active;
  logic [N-1:0] e_grant;
  logic         e_start, e_valid;
  logic [W-1:0] e_a, e_b;
  logic [1:0]   e_id;
  logic [7:0]   e_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_t0 = 0; m_ptr = 0; m_owner = 0; m_active = 0;
      e_grant = '0; e_start = 0; e_valid = 0; e_a = '0; e_b = '0; e_id = '0; e_data = '0;
    end else begin
      m_cyc++;
      e_grant = '0;
      if (!m_active) begin
        if (req != '0) begin
          m_w = -1;
          for (int k = 0; k < N; k++)
            if (m_w < 0 && req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
          m_active = 1;
          m_owner  = m_w;
          m_t0     = m_cyc;
          m_ptr    = (m_w + 1) % N;
          e_grant[m_w] = 1'b1;
          e_start  = 1'b1;
          e_a      = a_in[m_w*W +: W];
          e_b      = b_in[m_w*W +: W];
        end
      end else if (!e_valid) begin
        if (m_cyc - m_t0 == L) begin
          e_valid = 1'b1;
          e_id    = 2'(m_owner);
          e_data  = {4'b0, e_a} * {4'b0, e_b};
          e_start = 1'b0;
        end
      end else if (rsp_ready) begin
        e_valid  = 1'b0;
        m_active = 0;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (!rst) begin
      check("grant", 32'(grant), 32'(e_grant));
      check("mult_start", 32'(mult_start), 32'(e_start));
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      if (e_start) begin
        check("mult_a", 32'(mult_a), 32'(e_a));
        check("mult_b", 32'(mult_b), 32'(e_b));
      end
      if (e_valid) begin
        check("rsp_id", 32'(rsp_id), 32'(e_id));
        check("rsp_data", 32'(rsp_data), 32'(e_data));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors: grant log with timestamps, grant-to-valid latency, start length,
  // accepted responses.
  // ---------------------------------------------------------------------------
  int           tb_cyc = 0;
  int           start_cnt = 0;
  logic         prev_valid = 1'b0;
  logic [N-1:0] g_log[$];
  int           g_time[$];
  int           lat_q[$];
  int           len_q[$];
  logic [9:0]   rsp_log[$];

  always @(negedge clk) begin
    tb_cyc++;
    if (grant != '0) begin
      g_log.push_back(grant);
      g_time.push_back(tb_cyc);
      start_cnt = 0;
    end
    if (mult_start) start_cnt++;
    if (rsp_valid && !prev_valid && g_time.size() > 0) begin
      lat_q.push_back(tb_cyc - g_time[g_time.size()-1]);
      len_q.push_back(start_cnt);
    end
    prev_valid = rsp_valid;
  end

  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) rsp_log.push_back({rsp_id, rsp_data});
  end

  function automatic logic [31:0] g_at(input int i);
    return (i < g_log.size()) ? 32'(g_log[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] gt_at(input int i);
    return (i < g_time.size()) ? 32'(g_time[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] r_at(input int i);
    return (i < rsp_log.size()) ? 32'(rsp_log[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] last_lat();
    return (lat_q.size() > 0) ? 32'(lat_q[lat_q.size()-1]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] last_len();
    return (len_q.size() > 0) ? 32'(len_q[len_q.size()-1]) : 32'hFFFF_FFFF;
  endfunction

  // ---------------------------------------------------------------------------
  // Bounded waits
  // ---------------------------------------------------------------------------
  task automatic wait_grant(input int idx, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant[idx]) begin
        seen = 1;
        break;
      end
    end
    check($sformatf("grant%0d_arrives", idx), 32'(seen), 32'd1);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (rsp_log.size() >= n) begin
        seen = 1;
        break;
      end
    end
    check("rsp_arrives", 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    check("valid_arrives", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base_g, base_r;
    bit seen5;

    rst = 1'b1; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;

    // Idle after reset: nothing moves.
    repeat (6) @(negedge clk);
    #1;
    check("idle_no_grant", 32'(g_log.size()), 32'd0);
    check("idle_outputs", 32'({grant, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_data}), 32'd0);

    // All four requesting: rotation 0,1,2,3,0 with a_i=i+1, b_i=2.
    rsp_ready = 1'b1;
    a_in = {4'd4, 4'd3, 4'd2, 4'd1};
    b_in = {4'd2, 4'd2, 4'd2, 4'd2};
    req  = 4'b1111;
    base_g = g_log.size();
    base_r = rsp_log.size();
    seen5 = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk); #1;
      if (g_log.size() >= base_g + 5) begin
        seen5 = 1;
        break;
      end
    end
    check("rr_five_grants", 32'(seen5), 32'd1);
    req = '0;
    check("rr_grant0", g_at(base_g + 0), 32'b0001);
    check("rr_grant1", g_at(base_g + 1), 32'b0010);
    check("rr_grant2", g_at(base_g + 2), 32'b0100);
    check("rr_grant3", g_at(base_g + 3), 32'b1000);
    check("rr_grant4", g_at(base_g + 4), 32'b0001);
    check("rr_interval", gt_at(base_g + 1) - gt_at(base_g), 32'(L + 2));
    wait_rsp(base_r + 5, 40);
    check("rr_rsp0", r_at(base_r + 0), {22'd0, 2'd0, 8'd2});
    check("rr_rsp1", r_at(base_r + 1), {22'd0, 2'd1, 8'd4});
    check("rr_rsp2", r_at(base_r + 2), {22'd0, 2'd2, 8'd6});
    check("rr_rsp3", r_at(base_r + 3), {22'd0, 2'd3, 8'd8});
    check("rr_rsp4", r_at(base_r + 4), {22'd0, 2'd0, 8'd2});

    // Single requester 0: 3*5.
    base_r = rsp_log.size();
    a_in[3:0] = 4'd3; b_in[3:0] = 4'd5;
    req = 4'b0001;
    wait_grant(0, 10);
    #1 req = '0;
    wait_rsp(base_r + 1, 40);
    check("single_rsp", r_at(base_r), {22'd0, 2'd0, 8'd15});
    check("single_latency", last_lat(), 32'(L));
    check("single_start_len", last_len(), 32'(L));

    // Backpressure: 15*15 from requester 1, consumer stalls 5 cycles.
    rsp_ready = 1'b0;
    a_in[7:4] = 4'd15; b_in[7:4] = 4'd15;
    req = 4'b0010;
    wait_grant(1, 10);
    #1 req = '0;
    wait_valid(40);
    #1;
    a_in[11:8] = 4'd0; b_in[11:8] = 4'd9;
    req = 4'b0100;                       // waiting while the response is held
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data", 32'(rsp_data), 32'd225);
      check("hold_id", 32'(rsp_id), 32'd1);
      check("hold_no_grant", 32'(grant), 32'd0);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("handshake_no_grant", 32'(grant), 32'd0);
    check("handshake_valid_low", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("after_idle_grant", 32'(grant), 32'b0100);
    #1 req = '0;
    base_r = rsp_log.size();
    wait_rsp(base_r + 1, 40);
    check("zero_product", r_at(base_r), {22'd0, 2'd2, 8'd0});

    // Reset while BUSY at counter 8: operation dropped, pointer back to 0.
    a_in[15:12] = 4'd7; b_in[15:12] = 4'd7;
    req = 4'b1000;
    wait_grant(3, 10);
    #1 req = '0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_outputs", 32'({grant, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_data}), 32'd0);
    base_r = rsp_log.size();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    a_in[11:8] = 4'd6; b_in[11:8] = 4'd7;
    req = 4'b0100;
    wait_grant(2, 10);
    check("post_rst_grant", 32'(grant), 32'b0100);
    #1 req = '0;
    wait_rsp(base_r + 1, 40);
    check("post_rst_rsp", r_at(base_r), {22'd0, 2'd2, 8'd42});

    // Requester 1 drops its request while requester 0 is busy.
    base_r = rsp_log.size();
    a_in[3:0] = 4'd5; b_in[3:0] = 4'd3;
    a_in[15:12] = 4'd9; b_in[15:12] = 4'd9;
    req = 4'b0001;
    wait_grant(0, 10);
    #1 req = 4'b1010;
    repeat (3) @(negedge clk);
    #1 req = 4'b1000;
    wait_grant(3, 40);
    check("drop_grant", 32'(grant), 32'b1000);
    #1 req = '0;
    wait_rsp(base_r + 2, 40);
    check("drop_rsp0", r_at(base_r), {22'd0, 2'd0, 8'd15});
    check("drop_rsp1", r_at(base_r + 1), {22'd0, 2'd3, 8'd81});

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Round-robin scheduler that shares one pipelined multiplier (start/a/b/c interface, fixed calculation time) between NUM_REQ requesters.
- Accepts operands through a per-requester req/grant handshake and drives the multiplier's start, a and b.
- Waits MULT_LATENCY cycles, then captures the product and returns it with the requester id through a valid/ready response port.
- Sits between client blocks and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width; product width is 2*WIDTH.
- MULT_LATENCY, 16, cycles start is held before the multiplier output is valid (at least 1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high with operands stable until the matching grant.
- a_in  in  NUM_REQ*WIDTH  packed operand A; requester i uses slice [i*WIDTH +: WIDTH].
- b_in  in  NUM_REQ*WIDTH  packed operand B, same slicing as a_in.
- grant  out  NUM_REQ  one-hot, one-cycle pulse: operands of that requester were taken.
- mult_start  out  1  start to multiplier.
- mult_a  out  WIDTH  operand A to multiplier.
- mult_b  out  WIDTH  operand B to multiplier.
- mult_c  in  2*WIDTH  product from multiplier.
- rsp_valid  out  1  response available.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  2*WIDTH  captured product.
- rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Reset (asynchronous, any cycle):
  - All outputs go to 0.
  - State goes to IDLE, counter to 0, round-robin pointer to 0.
  - Any operation in flight is dropped and produces no response.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If req != 0 at edge E0, the winner is the first set bit at or above the pointer, wrapping modulo NUM_REQ.
  - After E0: grant[winner]=1 for exactly one cycle; mult_a/mult_b take the winner's slices; mult_start=1; winner id latched; pointer set to (winner+1) mod NUM_REQ; counter cleared; state goes to BUSY.
  - If req==0, nothing changes.
- BUSY:
  - mult_start stays 1 and mult_a/mult_b stay stable.
  - Counter increments on each edge.
  - At edge E_MULT_LATENCY (counter == MULT_LATENCY-1): rsp_data <= mult_c, rsp_id <= latched id, rsp_valid <= 1, mult_start <= 0, state goes to RESP.
  - mult_start is therefore high for exactly MULT_LATENCY cycles.
  - req is ignored during BUSY, including re-asserted or new requests.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until an edge with rsp_ready=1.
  - On that edge: rsp_valid <= 0 and state goes to IDLE.
  - No arbitration happens in the handshake cycle.
- Latency and throughput:
  - Grant to rsp_valid is MULT_LATENCY cycles.
  - Best-case issue interval is MULT_LATENCY+2 cycles (one BUSY run, one RESP cycle with rsp_ready=1, one IDLE cycle).
- Requester drop: if a requester drops req before its grant, it is simply not chosen. There is no error.
- Fairness: with all req bits held high, grants rotate 0,1,...,NUM_REQ-1,0.
- Arithmetic: no arithmetic in this block. The product is passed through unsigned, 2*WIDTH bits, unmodified.
- rsp_ready while rsp_valid=0 is ignored.

Decomposition:
- Shared package mult_defs:
  - FSM state encoding (IDLE=0, BUSY=1, RESP=2, 2-bit).
  - Default MULT_LATENCY=16 and WIDTH=4.
  - ID_W = clog2(NUM_REQ) function/macro.
- One sub-module, mult_rr_arbiter: combinational pick of the first set req bit at or above the pointer, with wrap. Outputs a one-hot vector, the winner index and an any-request flag.
- Top level holds the FSM, counter, operand and response registers.

Test Plan (NUM_REQ=4, WIDTH=4, MULT_LATENCY=16, bench multiplier model returns a*b after 16 start cycles):
- Reset for 4 cycles, then release with no requests -> every output is 0 and grant never pulses.
- req=0001, a0=3, b0=5, rsp_ready=1 -> grant=0001 for one cycle after E0; mult_start high 16 cycles; rsp_valid at E16 with rsp_id=0, rsp_data=15.
- req=1111 held, a_i=i+1, b_i=2 -> grant order 0001,0010,0100,1000,0001; responses (id,data) = (0,2),(1,4),(2,6),(3,8).
- Single op 15*15 with rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data=225, rsp_id stable and no grant while held; after rsp_ready=1, state is IDLE and the next request is granted one cycle later. Repeat with a=0, b=9 -> rsp_data=0.
- Assert rst at BUSY counter=8 -> all outputs 0 immediately and no response emitted; after release req=0100 is granted first, confirming the pointer reset to 0 and scan up to requester 2.
- req bit 1 dropped during BUSY of requester 0, req=1010 before that -> next grant goes to requester 3, not 1.
